// File: rtl/shift_register_full_unload.sv
// Serial-in, parallel-out collector: packs WIDTH-bit words into a DEPTH-word vector
// and holds it in a one-entry output register; flush emits a zero-padded partial vector.
module shift_register_full_unload #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clock,
  input  logic                             resetN,
  input  logic [WIDTH-1:0]                 in,
  input  logic                             inValid,
  output logic                             inReady,
  input  logic                             flush,
  output logic [DEPTH-1:0][WIDTH-1:0]      out,
  output logic                             outValid,
  input  logic                             outReady,
  output logic [$clog2(DEPTH+1)-1:0]       outCount
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] acc;
  logic [DEPTH-1:0][WIDTH-1:0] acc_next;
  logic [DEPTH-1:0][WIDTH-1:0] acc_merged;
  logic [DEPTH-1:0][WIDTH-1:0] out_masked;
  logic [DEPTH-1:0][WIDTH-1:0] out_next;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            cnt_next;
  logic [CNT_W-1:0]            fill;
  logic [CNT_W-1:0]            out_count_next;
  logic                        flush_pending;
  logic                        flush_pending_next;
  logic                        out_valid_next;
  logic                        slot_free;
  logic                        accept;
  logic                        flush_req;
  logic                        full;
  logic                        partial;
  logic                        xfer;

  // Handshake and transfer decisions; inReady is combinational from outReady.
  always_comb begin
    slot_free = !outValid || outReady;
    inReady   = slot_free || ((cnt < CNT_W'(DEPTH - 1)) && !flush_pending);
    accept    = inValid && inReady;
    flush_req = flush || flush_pending;
    full      = accept && (cnt == CNT_W'(DEPTH - 1));
    partial   = flush_req && ((cnt != '0) || accept);
    xfer      = slot_free && (full || partial);
    fill      = cnt + CNT_W'(accept);
  end

  // Accumulator with the incoming word merged in, and the zero-padded output image.
  always_comb begin
    acc_merged = acc;
    out_masked = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (accept && (cnt == CNT_W'(k))) begin
        acc_merged[k] = in;
      end
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < fill) begin
        out_masked[k] = acc_merged[k];
      end
    end
  end

  // Next-state: a transfer overrides the drain so a back-to-back vector has no bubble.
  always_comb begin
    acc_next           = acc;
    cnt_next           = cnt;
    flush_pending_next = flush_pending;
    out_next           = out;
    out_count_next     = outCount;
    out_valid_next     = outValid;
    if (xfer) begin
      out_next           = out_masked;
      out_count_next     = fill;
      out_valid_next     = 1'b1;
      cnt_next           = '0;
      acc_next           = '0;
      flush_pending_next = 1'b0;
    end else begin
      if (accept) begin
        acc_next = acc_merged;
        cnt_next = cnt + CNT_W'(1);
      end
      if (partial && !slot_free) begin
        flush_pending_next = 1'b1;
      end
      if (outValid && outReady) begin
        out_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      acc           <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
      out           <= '0;
      outCount      <= '0;
      outValid      <= 1'b0;
    end else begin
      acc           <= acc_next;
      cnt           <= cnt_next;
      flush_pending <= flush_pending_next;
      out           <= out_next;
      outCount      <= out_count_next;
      outValid      <= out_valid_next;
    end
  end

endmodule

// File: tb/tb_shift_register_full_unload.sv
// Bench for shift_register_full_unload: per-scenario tasks with inline checks plus a
// scoreboard of expected vectors compared whenever the consumer takes an output.
module tb_shift_register_full_unload;

  logic             clock = 1'b0;
  logic             resetN;
  logic [7:0]       din;
  logic             din_valid;
  logic             in_ready;
  logic             flush;
  logic [3:0][7:0]  dout;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_count;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  count;
  } vec_t;

  vec_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  shift_register_full_unload #(.WIDTH(8), .DEPTH(4)) dut (
    .clock    (clock),
    .resetN   (resetN),
    .in       (din),
    .inValid  (din_valid),
    .inReady  (in_ready),
    .flush    (flush),
    .out      (dout),
    .outValid (out_valid),
    .outReady (out_ready),
    .outCount (out_count)
  );

  always #5 clock = ~clock;

  // Scoreboard: every accepted output vector must match the oldest expectation.
  always @(negedge clock) begin
    if (resetN && out_valid && out_ready) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got out=%h count=%0d, expected no vector", dout, out_count);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        if (dout !== e.data || out_count !== e.count) begin
          fails++;
          $display("FAIL sb_vector: got out=%h count=%0d, expected out=%h count=%0d",
                   dout, out_count, e.data, e.count);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] data, input logic [2:0] count);
    vec_t e;
    e.data  = data;
    e.count = count;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    resetN    = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_count !== 3'd0 || dout !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b count=%0d out=%h, expected 0 0 0", out_valid, out_count, dout);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    tick();
    tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_single_vector();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = vals[i];
      din_valid = 1'b1;
      if (i == 3) push_exp(32'h44332211, 3'd4);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL single_in_ready[%0d]: got %b, expected 1", i, in_ready);
      end
      tick();
    end
    din_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || dout !== 32'h44332211 || out_count !== 3'd4) begin
      fails++;
      $display("FAIL single_vector: got valid=%b out=%h count=%0d, expected 1 44332211 4", out_valid, dout, out_count);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_drain: got valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      din = 8'(i + 1);
      din_valid = 1'b1;
      if (i == 3)  push_exp(32'h04030201, 3'd4);
      if (i == 7)  push_exp(32'h08070605, 3'd4);
      if (i == 11) push_exp(32'h0C0B0A09, 3'd4);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_in_ready[%0d]: got %b, expected 1", i, in_ready);
      end
      tick();
      tests++;
      if (out_valid !== ((i % 4) == 3)) begin
        fails++;
        $display("FAIL stream_valid[%0d]: got %b, expected %b", i, out_valid, (i % 4) == 3);
      end
    end
    din_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 8'hB0 + 8'(i);
      din_valid = 1'b1;
      if (i == 3) push_exp(32'hB3B2B1B0, 3'd4);
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = 8'hA0 + 8'(i);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL bp_accept[%0d]: got in_ready=%b, expected 1", i, in_ready);
      end
      tick();
    end
    din = 8'hA3;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_stall[%0d]: got in_ready=%b, expected 0", i, in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || dout !== 32'hB3B2B1B0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got valid=%b out=%h, expected 1 b3b2b1b0", i, out_valid, dout);
      end
    end
    out_ready = 1'b1;
    push_exp(32'hA3A2A1A0, 3'd4);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: got %b, expected 1", in_ready);
    end
    tick();
    din_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || dout !== 32'hA3A2A1A0 || out_count !== 3'd4) begin
      fails++;
      $display("FAIL bp_new_vector: got valid=%b out=%h count=%0d, expected 1 a3a2a1a0 4", out_valid, dout, out_count);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain: got valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    din = 8'h05; din_valid = 1'b1;
    tick();
    din = 8'h06;
    tick();
    din = 8'h07; flush = 1'b1;
    push_exp(32'h00070605, 3'd3);
    tick();
    din_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || dout !== 32'h00070605 || out_count !== 3'd3) begin
      fails++;
      $display("FAIL flush_partial: got valid=%b out=%h count=%0d, expected 1 00070605 3", out_valid, dout, out_count);
    end
    tick();
    flush = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_empty: got valid=%b, expected 0", out_valid);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_empty_after: got valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush_pending();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 8'hC0 + 8'(i);
      din_valid = 1'b1;
      if (i == 3) push_exp(32'hC3C2C1C0, 3'd4);
      tick();
    end
    out_ready = 1'b0;
    din = 8'hD0;
    tick();
    din = 8'hD1;
    tick();
    din_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    din = 8'hEE; din_valid = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL pending_in_ready: got %b, expected 0", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || dout !== 32'hC3C2C1C0) begin
      fails++;
      $display("FAIL pending_hold: got valid=%b out=%h, expected 1 c3c2c1c0", out_valid, dout);
    end
    din_valid = 1'b0;
    out_ready = 1'b1;
    push_exp(32'h0000D1D0, 3'd2);
    tick();
    tests++;
    if (out_valid !== 1'b1 || dout !== 32'h0000D1D0 || out_count !== 3'd2) begin
      fails++;
      $display("FAIL pending_xfer: got valid=%b out=%h count=%0d, expected 1 0000d1d0 2", out_valid, dout, out_count);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL pending_drain: got valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    din = 8'hF0; din_valid = 1'b1;
    tick();
    din = 8'hF1;
    tick();
    din_valid = 1'b0;
    #2 resetN = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || dout !== 32'h0 || out_count !== 3'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_fill: got valid=%b out=%h count=%0d in_ready=%b, expected 0 0 0 1", out_valid, dout, out_count, in_ready);
    end
    @(negedge clock);
    resetN = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = 8'h90 + 8'(i);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || dout !== 32'h93929190) begin
      fails++;
      $display("FAIL reset_hold_setup: got valid=%b out=%h, expected 1 93929190", out_valid, dout);
    end
    #2 resetN = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || dout !== 32'h0 || out_count !== 3'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_hold: got valid=%b out=%h count=%0d in_ready=%b, expected 0 0 0 1", out_valid, dout, out_count, in_ready);
    end
    @(negedge clock);
    resetN = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 8'h61 + 8'(i);
      din_valid = 1'b1;
      if (i == 3) push_exp(32'h64636261, 3'd4);
      tick();
    end
    din_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || dout !== 32'h64636261 || out_count !== 3'd4) begin
      fails++;
      $display("FAIL reset_refill: got valid=%b out=%h count=%0d, expected 1 64636261 4", out_valid, dout, out_count);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_stream();
    test_back_to_back();
    test_flush();
    test_flush_pending();
    test_reset_mid();
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d unconsumed vectors, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_register_full_unload.md
# shift_register_full_unload

Serial-in, parallel-out collector: the receive-side counterpart to the team's full-load shift register. It accepts WIDTH-bit words one per cycle over a valid/ready handshake and packs them into a DEPTH-word vector, with the first word received at index 0. It presents each completed vector through a one-entry output register with its own valid/ready handshake. A flush request emits a partially filled, zero-padded vector. It sits between serial producers, such as accumulator drain paths, and wide consumers.

## Interface
- WIDTH, 8, bits per word
- DEPTH, 4, words per vector; DEPTH ≥ 2
- clock  input  1  rising-edge clock
- resetN  input  1  asynchronous, active-low reset
- in  input  WIDTH  serial word
- inValid  input  1  `in` is valid
- inReady  output  1  block accepts `in` this cycle
- flush  input  1  request to emit the current partial vector
- out  output  [DEPTH-1:0][WIDTH-1:0]  packed vector; word k is the k-th word received
- outValid  output  1  `out` holds a vector
- outReady  input  1  consumer takes `out` this cycle
- outCount  output  $clog2(DEPTH+1)  number of valid words in `out` (1..DEPTH); upper words are zero

## Operation
- State:
  - accumulator `acc[DEPTH-1:0]`
  - fill counter `cnt` (0..DEPTH-1)
  - output register `out` / `outCount` / `outValid`
  - `flushPending` flag
- Reset (resetN low, asynchronous): acc, cnt, out, outCount, outValid and flushPending all clear to 0.
  - inReady therefore reads 1 during and after reset.
- Definitions:
  - accept = inValid && inReady
  - slotFree = !outValid || outReady
  - flushReq = flush || flushPending
- inReady = slotFree || (cnt < DEPTH-1 && !flushPending). This is combinational from outReady by design.
- On accept:
  - `in` is written to acc[cnt].
  - cnt increments unless a transfer occurs.
- Transfer to output when slotFree and either:
  - (a) accept && cnt == DEPTH-1 (full), or
  - (b) flushReq && (cnt > 0 || accept) (partial).
- On transfer:
  - out ← acc with the incoming word (if accepted) at index cnt; all indices ≥ the final word count are forced to 0.
  - outCount ← cnt + accept.
  - outValid ← 1.
  - cnt ← 0, acc ← 0, flushPending ← 0.
- Flush blocked: if flushReq && (cnt > 0 || accept) && !slotFree, set flushPending. inReady is then 0 until the transfer occurs.
- Flush with cnt == 0 and no accept is a no-op; flushPending is not set and there is no empty-vector output.
- Output drain: if outValid && outReady and no transfer this cycle, outValid ← 0. out and outCount retain their last value.
- A word accepted in the same cycle as a flush is included in the flushed vector.
- Simultaneous output drain and transfer: the new vector replaces the old one, and outValid stays 1 (no bubble).

## Timing
- Latency:
  - last word accepted at edge N → outValid = 1 from edge N onward (visible in cycle N+1).
  - flush with slotFree at edge N → partial vector valid after edge N.
- Throughput: one word per cycle sustained while outReady = 1; one full vector every DEPTH cycles with no stall cycles.
- Backpressure:
  - with outValid = 1 and outReady = 0, the block accepts DEPTH-1 further words, then deasserts inReady.
  - the DEPTH-th word is accepted in the first cycle outReady = 1.
- resetN asserted mid-fill or mid-hold discards all data immediately; there is no partial output.

## Test plan
- DEPTH=4, WIDTH=8, outReady=1; feed 0x11,0x22,0x33,0x44 back-to-back → one cycle after 0x44, outValid=1, out={0x44,0x33,0x22,0x11} (index 3..0), outCount=4; inReady stays 1 throughout.
- Continuous stream 0x01..0x0C with outReady=1 → three vectors on cycles 4, 8 and 12 with no idle input cycles; outValid is high for exactly one cycle each.
- outReady=0 after the first vector; feed 0xA0..0xA3 → 0xA0..0xA2 accepted, inReady=0 while 0xA3 is offered; raise outReady → 0xA3 accepted that cycle, new vector {A3,A2,A1,A0} valid next cycle with no outValid gap.
- Feed 0x05,0x06, then flush together with 0x07 → out={0x00,0x07,0x06,0x05}, outCount=3; a flush with cnt=0 and inValid=0 produces no outValid.
- Flush with 2 words held and outValid=1, outReady=0 → flushPending set, inReady=0; when outReady=1, the partial vector (outCount=2) transfers the same cycle.
- Pull resetN low mid-fill (cnt=2) and while outValid=1 → outValid, cnt and out are 0 immediately; after release, inReady=1 and a fresh 4-word fill produces a correct vector.
